// File: rtl/dragon_pkg.sv
// Shared dragon definitions: behaviour/direction encodings, coordinate widths
// and the tile distance metric used by both the controller and the head datapath.
package dragon_pkg;

  localparam int COORD_W = 4;
  localparam int LOC_W   = 2 * COORD_W;
  localparam int DIST_W  = COORD_W + 1;

  typedef enum logic [1:0] {
    ST_CONTEST = 2'b00,
    ST_RETREAT = 2'b01,
    ST_SCATTER = 2'b10,
    ST_DEAD    = 2'b11
  } behaviour_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } direction_t;

  // Each axis difference gets one extra bit so the 0..30 sum never wraps.
  function automatic logic [DIST_W-1:0] manhattan(input logic [LOC_W-1:0] a,
                                                   input logic [LOC_W-1:0] b);
    logic [DIST_W-1:0] dx;
    logic [DIST_W-1:0] dy;
    dx = (a[LOC_W-1:COORD_W] >= b[LOC_W-1:COORD_W]) ?
         {1'b0, a[LOC_W-1:COORD_W] - b[LOC_W-1:COORD_W]} :
         {1'b0, b[LOC_W-1:COORD_W] - a[LOC_W-1:COORD_W]};
    dy = (a[COORD_W-1:0] >= b[COORD_W-1:0]) ?
         {1'b0, a[COORD_W-1:0] - b[COORD_W-1:0]} :
         {1'b0, b[COORD_W-1:0] - a[COORD_W-1:0]};
    return dx + dy;
  endfunction

endpackage

// File: rtl/dragon_controller_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4); maximal length, so a non-zero seed
// never reaches the all-zero state.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       frame_clk,
  input  logic       rst_n,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] lfsr_r;
  logic       feedback_s;

  assign feedback_s = lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3];
  assign value      = lfsr_r;

  // Shift register, advanced only on requested frames.
  always_ff @(posedge frame_clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= SEED;
    end else if (advance) begin
      lfsr_r <= {lfsr_r[6:0], feedback_s};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

endmodule

// File: rtl/dragon_controller.sv
// Dragon behaviour controller: CONTEST/RETREAT/SCATTER/DEAD state machine,
// per-frame target selection, movement step strobe and body length.
module dragon_controller
  import dragon_pkg::*;
#(
  parameter int MOVE_PERIOD    = 8,
  parameter int RETREAT_FRAMES = 120,
  parameter int SCATTER_FRAMES = 90,
  parameter int INIT_LENGTH    = 3,
  parameter int MAX_LENGTH     = 9
) (
  input  logic       frame_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] player_location,
  input  logic [7:0] sheep_location,
  input  logic [7:0] dragon_head_location,
  input  logic       dragon_hurt,
  output logic [7:0] target_tile,
  output logic       step_en,
  output logic [1:0] behaviour_state,
  output logic [3:0] dragon_length,
  output logic       sheep_respawn,
  output logic       dragon_dead
);

  localparam int CNT_W   = (MOVE_PERIOD > 2) ? $clog2(MOVE_PERIOD) : 1;
  localparam int TMR_MAX = (RETREAT_FRAMES > SCATTER_FRAMES) ? RETREAT_FRAMES : SCATTER_FRAMES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  behaviour_t        state_r, state_s;
  logic [7:0]        target_r, target_s;
  logic [3:0]        length_r, length_s;
  logic              step_en_r, respawn_r, respawn_s;
  logic [CNT_W-1:0]  step_cnt_r, step_cnt_s;
  logic [TMR_W-1:0]  timer_r;
  logic [7:0]        lfsr_s;
  logic [7:0]        corner_s;
  logic [DIST_W-1:0] dist_player_s, dist_sheep_s;
  logic              hurt_ok_s, win_s, arrived_s;

  lfsr8 #(.SEED(8'hA5)) u_lfsr (
    .frame_clk (frame_clk),
    .rst_n     (rst_n),
    .advance   (enable),
    .value     (lfsr_s)
  );

  assign dist_player_s = manhattan(dragon_head_location, player_location);
  assign dist_sheep_s  = manhattan(dragon_head_location, sheep_location);
  assign corner_s      = {(player_location[7:4] < 4'd8) ? 4'hF : 4'h0,
                          (player_location[3:0] < 4'd8) ? 4'hF : 4'h0};
  assign hurt_ok_s     = dragon_hurt && ((state_r == ST_CONTEST) || (state_r == ST_SCATTER));
  assign win_s         = (state_r == ST_CONTEST) && (dragon_head_location == sheep_location);
  assign arrived_s     = (dragon_head_location == target_r);
  assign step_cnt_s    = (step_cnt_r == CNT_W'(MOVE_PERIOD - 1)) ? {CNT_W{1'b0}}
                                                                  : step_cnt_r + CNT_W'(1);

  // Next state/target/length; hurt outranks a win, which outranks arrival or timeout.
  always_comb begin
    state_s   = state_r;
    target_s  = target_r;
    length_s  = length_r;
    respawn_s = 1'b0;
    if (hurt_ok_s) begin
      if (length_r == 4'd1) begin
        length_s = 4'd0;
        state_s  = ST_DEAD;
      end else begin
        length_s = length_r - 4'd1;
        state_s  = ST_RETREAT;
        target_s = corner_s;
      end
    end else if (win_s) begin
      state_s   = ST_SCATTER;
      target_s  = lfsr_s;
      respawn_s = 1'b1;
      if (length_r < 4'(MAX_LENGTH)) begin
        length_s = length_r + 4'd1;
      end else begin
        length_s = length_r;
      end
    end else begin
      case (state_r)
        ST_CONTEST: target_s = (dist_player_s < dist_sheep_s) ? player_location : sheep_location;
        ST_RETREAT: begin
          if (arrived_s || (timer_r == TMR_W'(RETREAT_FRAMES - 1))) begin
            state_s = ST_CONTEST;
          end else begin
            state_s = ST_RETREAT;
          end
        end
        ST_SCATTER: begin
          if (arrived_s || (timer_r == TMR_W'(SCATTER_FRAMES - 1))) begin
            state_s = ST_CONTEST;
          end else begin
            state_s = ST_SCATTER;
          end
        end
        ST_DEAD:    state_s = ST_DEAD;
        default:    state_s = ST_CONTEST;
      endcase
    end
  end

  // Registered behaviour; everything but the strobes freezes while disabled.
  always_ff @(posedge frame_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_CONTEST;
      target_r   <= 8'h00;
      length_r   <= 4'(INIT_LENGTH);
      step_en_r  <= 1'b0;
      respawn_r  <= 1'b0;
      step_cnt_r <= {CNT_W{1'b0}};
      timer_r    <= {TMR_W{1'b0}};
    end else if (enable) begin
      state_r    <= state_s;
      target_r   <= target_s;
      length_r   <= length_s;
      respawn_r  <= respawn_s;
      step_cnt_r <= step_cnt_s;
      step_en_r  <= (step_cnt_s == CNT_W'(MOVE_PERIOD - 1)) && (state_s != ST_DEAD);
      if (state_s != state_r) begin
        timer_r <= {TMR_W{1'b0}};
      end else if (timer_r != {TMR_W{1'b1}}) begin
        timer_r <= timer_r + TMR_W'(1);
      end else begin
        timer_r <= timer_r;
      end
    end else begin
      step_en_r <= 1'b0;
      respawn_r <= 1'b0;
    end
  end

  assign target_tile     = target_r;
  assign step_en         = step_en_r;
  assign behaviour_state = state_r;
  assign dragon_length   = length_r;
  assign sheep_respawn   = respawn_r;
  assign dragon_dead     = (state_r == ST_DEAD);

endmodule

// File: tb/tb_dragon_controller.sv
// Directed bench for dragon_controller: table of contest vectors plus sequences
// for eating, hurt/retreat, freeze, reset and death (second instance, max length 1).
module tb_dragon_controller;

  logic       frame_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] player = 8'h00, sheep = 8'h00, head = 8'h00;
  logic       hurt = 1'b0;

  logic [7:0] target, mn_target;
  logic       step_en, mn_step_en, respawn, mn_respawn, dead, mn_dead;
  logic [1:0] state, mn_state;
  logic [3:0] length, mn_length;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_lfsr;
  logic [7:0] lf;
  logic [3:0] exp_len;
  int main_steps, mn_steps;

  typedef struct {
    logic       en;
    logic [7:0] player;
    logic [7:0] sheep;
    logic [7:0] head;
    logic       hurt;
    logic [7:0] exp_target;
    logic [1:0] exp_state;
    logic [3:0] exp_len;
    logic       exp_step;
  } vec_t;
  vec_t vecs[11];

  dragon_controller dut (
    .frame_clk(frame_clk), .rst_n(rst_n), .enable(enable),
    .player_location(player), .sheep_location(sheep), .dragon_head_location(head),
    .dragon_hurt(hurt), .target_tile(target), .step_en(step_en),
    .behaviour_state(state), .dragon_length(length),
    .sheep_respawn(respawn), .dragon_dead(dead)
  );

  dragon_controller #(.INIT_LENGTH(1), .MAX_LENGTH(1)) dut_min (
    .frame_clk(frame_clk), .rst_n(rst_n), .enable(enable),
    .player_location(player), .sheep_location(sheep), .dragon_head_location(head),
    .dragon_hurt(hurt), .target_tile(mn_target), .step_en(mn_step_en),
    .behaviour_state(mn_state), .dragon_length(mn_length),
    .sheep_respawn(mn_respawn), .dragon_dead(mn_dead)
  );

  always #5 frame_clk = ~frame_clk;

  // Reference LFSR: seed A5, taps 8,6,5,4, advances on enabled frames.
  always @(posedge frame_clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else if (enable) m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic frame();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  task automatic chk_reset_values();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_target", 32'(target), 32'h00);
    chk("rst_step", 32'(step_en), 32'd0);
    chk("rst_len", 32'(length), 32'd3);
    chk("rst_respawn", 32'(respawn), 32'd0);
    chk("rst_dead", 32'(dead), 32'd0);
    chk("rst_min_len", 32'(mn_length), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'h57, 8'h75, 8'h55, 1'b0, 8'h75, 2'd0, 4'd3, 1'b0};
    vecs[1]  = '{1'b1, 8'h11, 8'h33, 8'h00, 1'b0, 8'h11, 2'd0, 4'd3, 1'b0};
    vecs[2]  = '{1'b1, 8'h00, 8'hF0, 8'hFF, 1'b0, 8'hF0, 2'd0, 4'd3, 1'b0};
    vecs[3]  = '{1'b1, 8'h8F, 8'h08, 8'h80, 1'b0, 8'h8F, 2'd0, 4'd3, 1'b0};
    vecs[4]  = '{1'b1, 8'h2C, 8'h6D, 8'h4A, 1'b0, 8'h2C, 2'd0, 4'd3, 1'b0};
    vecs[5]  = '{1'b1, 8'h4A, 8'h4B, 8'h4A, 1'b0, 8'h4A, 2'd0, 4'd3, 1'b0};
    vecs[6]  = '{1'b1, 8'hF7, 8'h0F, 8'h07, 1'b0, 8'h0F, 2'd0, 4'd3, 1'b1};
    vecs[7]  = '{1'b1, 8'h78, 8'h76, 8'h77, 1'b0, 8'h76, 2'd0, 4'd3, 1'b0};
    vecs[8]  = '{1'b0, 8'h12, 8'h99, 8'h11, 1'b0, 8'h76, 2'd0, 4'd3, 1'b0};
    vecs[9]  = '{1'b0, 8'h57, 8'h75, 8'h55, 1'b1, 8'h76, 2'd0, 4'd3, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 8'h3C, 8'h3C, 1'b0, 8'h76, 2'd0, 4'd3, 1'b0};

    @(negedge frame_clk);
    chk_reset_values();
    rst_n = 1'b1;

    // Contest target selection, step phase and frozen frames.
    for (int i = 0; i < 11; i++) begin
      enable = vecs[i].en; player = vecs[i].player; sheep = vecs[i].sheep;
      head = vecs[i].head; hurt = vecs[i].hurt;
      frame();
      chk($sformatf("vec%0d_target", i), 32'(target), 32'(vecs[i].exp_target));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      chk($sformatf("vec%0d_len", i), 32'(length), 32'(vecs[i].exp_len));
      chk($sformatf("vec%0d_step", i), 32'(step_en), 32'(vecs[i].exp_step));
      chk($sformatf("vec%0d_respawn", i), 32'(respawn), 32'd0);
    end
    hurt = 1'b0;

    // Eat the sheep repeatedly: length 4..9 then saturation.
    enable = 1'b1; player = 8'h00; exp_len = 4'd3;
    for (int k = 0; k < 7; k++) begin
      head = 8'h3C; sheep = 8'h3C; lf = m_lfsr;
      frame();
      exp_len = (exp_len < 4'd9) ? exp_len + 4'd1 : exp_len;
      chk("eat_state", 32'(state), 32'd2);
      chk("eat_len", 32'(length), 32'(exp_len));
      chk("eat_respawn", 32'(respawn), 32'd1);
      chk("eat_target", 32'(target), 32'(lf));
      head = lf ^ 8'h01;
      frame();
      chk("eat_respawn_once", 32'(respawn), 32'd0);
      chk("scatter_hold", 32'(state), 32'd2);
      head = lf;
      frame();
      chk("scatter_arrive", 32'(state), 32'd0);
    end

    // Hurt in CONTEST, then invulnerable in RETREAT.
    player = 8'h21; sheep = 8'h3C; head = 8'h55; hurt = 1'b1;
    frame();
    chk("hurt_state", 32'(state), 32'd1);
    chk("hurt_len", 32'(length), 32'd8);
    chk("hurt_target", 32'(target), 32'hFF);
    hurt = 1'b0; frame();
    hurt = 1'b1; frame();
    chk("retreat_invuln_len", 32'(length), 32'd8);
    chk("retreat_invuln_state", 32'(state), 32'd1);
    hurt = 1'b0;

    // Retreat timeout after 120 enabled frames, with a 20-frame freeze inside.
    repeat (58) frame();
    chk("retreat_mid", 32'(state), 32'd1);
    enable = 1'b0;
    for (int f = 0; f < 20; f++) begin
      frame();
      chk("freeze_step", 32'(step_en), 32'd0);
    end
    chk("freeze_state", 32'(state), 32'd1);
    enable = 1'b1;
    repeat (59) frame();
    chk("retreat_119", 32'(state), 32'd1);
    chk("retreat_target_held", 32'(target), 32'hFF);
    frame();
    chk("retreat_timeout", 32'(state), 32'd0);

    // Asynchronous reset in the middle of RETREAT.
    hurt = 1'b1; frame(); hurt = 1'b0;
    chk("hurt2_len", 32'(length), 32'd7);
    frame(); frame();
    #2 rst_n = 1'b0;
    #1 chk_reset_values();
    @(negedge frame_clk);
    rst_n = 1'b1;

    // Death: the max-length-1 instance stays at length 1 through SCATTER.
    player = 8'h00; head = 8'h3C; sheep = 8'h3C;
    frame();
    chk("d_eat_state", 32'(state), 32'd2);
    chk("d_eat_len", 32'(length), 32'd4);
    chk("d_eat_target", 32'(target), 32'hA5);
    chk("min_eat_state", 32'(mn_state), 32'd2);
    chk("min_eat_len", 32'(mn_length), 32'd1);
    chk("min_eat_respawn", 32'(mn_respawn), 32'd1);
    head = 8'hA4; hurt = 1'b1;
    frame();
    hurt = 1'b0;
    chk("min_dead_state", 32'(mn_state), 32'd3);
    chk("min_dead_len", 32'(mn_length), 32'd0);
    chk("min_dead_flag", 32'(mn_dead), 32'd1);
    chk("scatter_hurt_state", 32'(state), 32'd1);
    chk("scatter_hurt_len", 32'(length), 32'd3);
    chk("main_not_dead", 32'(dead), 32'd0);
    main_steps = 0; mn_steps = 0;
    for (int f = 0; f < 100; f++) begin
      frame();
      if (step_en) main_steps++;
      if (mn_step_en) mn_steps++;
    end
    chk("dead_no_step", 32'(mn_steps), 32'd0);
    chk("main_step_count", 32'(main_steps), 32'd12);
    chk("dead_terminal", 32'(mn_state), 32'd3);
    chk("dead_target_hold", 32'(mn_target), 32'hA5);
    chk("dead_flag_hold", 32'(mn_dead), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
